cpu_rf_mp: RTL
==============

Name: cpu_rf_mp

Overview:
- Parametrised multi-port successor to the CPU register file.
- Width, depth and read-port count are configurable; two write ports with fixed priority.
- Registered reads with optional write-through bypass, optional hard-wired zero register, and a per-register busy scoreboard for pending writes.
- Sits between CPU decode (reads, allocation) and writeback (write ports).

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 16, number of registers; need not be a power of two, minimum 2.
- NUM_RD, 2, number of read ports, 1..4.
- ZERO_REG, 1, if 1, R0 is constant zero; if 0, R0 is general purpose.
- BYPASS, 1, if 1, same-cycle write data is forwarded to the read outputs.
- ADDR_W, $clog2(NUM_REGS), derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_en  in  NUM_RD  per-port read enable.
- rd_sel  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  registered read data, packed like rd_sel.
- wr0_en  in  1  write port 0 enable (low priority).
- wr0_sel  in  ADDR_W  write port 0 address.
- wr0_data  in  DATA_W  write port 0 data.
- wr1_en  in  1  write port 1 enable (high priority).
- wr1_sel  in  ADDR_W  write port 1 address.
- wr1_data  in  DATA_W  write port 1 data.
- alloc_en  in  1  mark a register as having a pending write.
- alloc_sel  in  ADDR_W  register to allocate.
- busy  out  NUM_REGS  scoreboard; bit r=1 means register r has a pending write.
- err  out  1  registered one-cycle error pulse.
- err_sticky  out  1  latched error flag.
- err_clr  in  1  clears err_sticky.

Behaviour:
- Reset (rst=1, async): all registers, rd_data, busy, err and err_sticky go to 0 immediately and hold while rst is high.
- Write:
  - On a clock edge with wrN_en=1 and a valid address, wrN_data is stored.
  - wr0 and wr1 to the same address in one cycle: wr1 data is stored and err is raised.
- Valid address: sel < NUM_REGS. When ZERO_REG=1, also sel != 0 for writes.
- Invalid writes:
  - Out of range: no store; raises err.
  - Write to R0 with ZERO_REG=1: no store; raises err only if data != 0.
- Read:
  - 1-cycle latency. With rd_en[i]=1 at edge k, rd_data[i] shows the value from edge k onward.
  - With rd_en[i]=0, rd_data[i] holds its previous value.
- Bypass:
  - BYPASS=1 and a same-cycle write targets rd_sel[i]: rd_data[i] takes the winning write data (wr1 over wr0).
  - BYPASS=0: rd_data[i] takes the pre-write contents.
- Read special cases:
  - Read of R0 with ZERO_REG=1: always 0, even if bypass applies.
  - Out-of-range read: 0, no error.
- Scoreboard:
  - alloc_en with a valid alloc_sel sets busy[alloc_sel] at the next edge.
  - A stored write to register r clears busy[r].
  - Same-cycle alloc and write to the same register: alloc wins, busy stays 1.
  - Alloc to R0 (ZERO_REG=1) or out of range: ignored, no error.
  - Writes to a non-busy register are legal and do not flag.
- Errors:
  - err is high for exactly the cycle after each edge that had an error condition. Multiple conditions in one cycle give a single pulse.
  - err_sticky is set by any error condition. err_clr clears it at the next edge.
  - Error condition and err_clr in the same cycle: set wins.
- No combinational path from any input to any output.

Test Plan:
- Reset release, no stimulus, then read R1..R15 on both ports -> every rd_data=0, busy=0, err=0.
- wr0 R3=0xDEADBEEF with rd_sel[0]=3, rd_en=1 in the same cycle -> BYPASS=1: rd_data[0]=0xDEADBEEF next cycle; BYPASS=0: 0, then 0xDEADBEEF on the following read.
- wr0 R5=0x1111 and wr1 R5=0x2222 together -> R5 reads 0x2222; err pulses for 1 cycle; err_sticky=1 until an err_clr edge.
- ZERO_REG=1: write R0=0x5 -> err pulses, R0 reads 0. Write R0=0 -> no err.
- alloc R7, then wr1 R7=0xA5 two cycles later -> busy[7] is 1 for two cycles, then 0. Alloc R7 together with a write to R7 -> busy[7] stays 1.
- NUM_REGS=12, NUM_RD=3: write sel=13 -> err, no store; read sel=13 on port 2 -> 0. Assert rst mid-write -> all state is 0 asynchronously.

Source files
------------

// File: rtl/cpu_rf_mp.sv
// cpu_rf_mp: parametrised multi-port register file.
// Two prioritised write ports, registered reads, busy scoreboard.
module cpu_rf_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_sel,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_sel,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_sel,
    output logic [NUM_REGS-1:0]      busy,
    output logic                     err,
    output logic                     err_sticky,
    input  logic                     err_clr
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS);
    localparam bit HAS_ZERO = (ZERO_REG != 0);
    localparam bit HAS_BYP  = (BYPASS != 0);

    // Address lies inside the implemented register range.
    function automatic logic in_range(input logic [ADDR_W-1:0] sel);
        return {1'b0, sel} < LIMIT;
    endfunction

    // Address is the hard-wired zero register.
    function automatic logic is_zero(input logic [ADDR_W-1:0] sel);
        return HAS_ZERO && (sel == '0);
    endfunction

    logic [DATA_W-1:0]         regs [NUM_REGS];
    logic [NUM_RD*DATA_W-1:0]  rd_q;
    logic [DATA_W-1:0]         rd_nxt [NUM_RD];
    logic [ADDR_W-1:0]         rd_addr [NUM_RD];
    logic [NUM_REGS-1:0]       busy_q;
    logic [NUM_REGS-1:0]       w_hit;
    logic [NUM_REGS-1:0]       a_hit;
    logic                      w0_ok;
    logic                      w1_ok;
    logic                      w0_bad;
    logic                      w1_bad;
    logic                      w_clash;
    logic                      a_ok;
    logic                      err_cond;
    logic                      err_q;
    logic                      sticky_q;

    // Classify this cycle's writes and allocation; collect error sources.
    always_comb begin
        w0_ok    = wr0_en && in_range(wr0_sel) && !is_zero(wr0_sel);
        w1_ok    = wr1_en && in_range(wr1_sel) && !is_zero(wr1_sel);
        w0_bad   = wr0_en && (!in_range(wr0_sel) ||
                   (is_zero(wr0_sel) && (wr0_data != '0)));
        w1_bad   = wr1_en && (!in_range(wr1_sel) ||
                   (is_zero(wr1_sel) && (wr1_data != '0)));
        w_clash  = wr0_en && wr1_en && (wr0_sel == wr1_sel);
        a_ok     = alloc_en && in_range(alloc_sel) && !is_zero(alloc_sel);
        err_cond = w0_bad || w1_bad || w_clash;
    end

    // Per-register decode of stored writes and allocations.
    always_comb begin
        w_hit = '0;
        a_hit = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_hit[r] = (w0_ok && (wr0_sel == ADDR_W'(r))) ||
                       (w1_ok && (wr1_sel == ADDR_W'(r)));
            a_hit[r] = a_ok && (alloc_sel == ADDR_W'(r));
        end
    end

    // Next read value per port: zero/out-of-range, bypass, or array.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr[i] = rd_sel[i*ADDR_W +: ADDR_W];
            rd_nxt[i]  = '0;
            if (in_range(rd_addr[i]) && !is_zero(rd_addr[i])) begin
                if (HAS_BYP && w1_ok && (wr1_sel == rd_addr[i]))
                    rd_nxt[i] = wr1_data;
                else if (HAS_BYP && w0_ok && (wr0_sel == rd_addr[i]))
                    rd_nxt[i] = wr0_data;
                else
                    rd_nxt[i] = regs[rd_addr[i]];
            end
        end
    end

    // Register array; write port 1 overrides port 0 on a shared target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w1_ok && (wr1_sel == ADDR_W'(r)))
                    regs[r] <= wr1_data;
                else if (w0_ok && (wr0_sel == ADDR_W'(r)))
                    regs[r] <= wr0_data;
            end
        end
    end

    // Read data registers; disabled ports hold their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (rd_en[i])
                    rd_q[i*DATA_W +: DATA_W] <= rd_nxt[i];
            end
        end
    end

    // Scoreboard: allocation sets, a stored write clears, alloc wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (a_hit[r])
                    busy_q[r] <= 1'b1;
                else if (w_hit[r])
                    busy_q[r] <= 1'b0;
            end
        end
    end

    // Error pulse and sticky flag; a new error beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            err_q <= err_cond;
            if (err_cond)
                sticky_q <= 1'b1;
            else if (err_clr)
                sticky_q <= 1'b0;
        end
    end

    assign rd_data    = rd_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;

endmodule
